uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per bit period (range 8..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (range 5..9).
REQ-003 SHALL have parameter PARITY_MODE, default 0, parity: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rx  input  1  serial line, idle high.
REQ-008 SHALL have port out_data  output  DATA_BITS  received word, LSB first on line.
REQ-009 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts word when high with out_valid.
REQ-011 SHALL have port frame_err  output  1  stop bit sampled low for word in out_data.
REQ-012 SHALL have port parity_err  output  1  parity mismatch for word in out_data.
REQ-013 SHALL have port overrun  output  1  a word completed while out_valid was high.
REQ-014 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE=0.
REQ-016 SHALL leave IDLE for START on first cycle rx (post-sync) is 0, clearing bit counter and bit index.
REQ-017 SHALL, in START, resample rx when counter reaches CLKS_PER_BIT/2-1: 0 -> DATA with counter cleared; 1 -> IDLE (glitch, no output).
REQ-018 SHALL, in DATA/PARITY/STOP, sample rx when counter reaches CLKS_PER_BIT-1, then clear counter; otherwise increment.
REQ-019 SHALL shift DATA_BITS samples LSB first, then enter PARITY or STOP.
REQ-020 SHALL compute parity error as XOR of data bits and parity sample, not equal to 0 (even) or 1 (odd).
REQ-021 SHALL flag framing error if any of the STOP_BITS stop samples is 0; frame still delivered.
REQ-022 SHALL, one cycle after the final stop sample, load out_data, frame_err, parity_err, assert out_valid, return to IDLE.
REQ-023 SHALL clear out_valid on the cycle after out_valid && out_ready; errors held until next load.
REQ-024 SHALL, on load while out_valid high and out_ready low, overwrite out_data and set overrun; overrun is sticky until a handshake completes.
REQ-025 SHALL, on load coincident with out_valid && out_ready, treat old word as consumed (no overrun).
REQ-026 SHALL size counter as $clog2(CLKS_PER_BIT) bits; counter never wraps past CLKS_PER_BIT-1.

Reset
REQ-027 SHALL, on rst low at any time including mid-frame, force IDLE, counters 0, out_data 0, out_valid 0, frame_err 0, parity_err 0, overrun 0, busy 0, synchronizer flops 1.
REQ-028 SHALL resume by waiting for a new falling edge after rst release.

Configuration
REQ-029 SHALL, with UART_RX_SYNC_EN defined, pass rx through a two-flop synchronizer (reset to 1), adding 2 cycles latency to all sampling.
REQ-030 SHALL, without UART_RX_SYNC_EN, use rx directly; no other behaviour changes.

Structure
REQ-031 SHALL place state enum and parity mode constants (PARITY_NONE/EVEN/ODD) in package uart_pkg.
REQ-032 SHALL implement the synchronizer as sub-module uart_rx_sync, instantiated only under UART_RX_SYNC_EN.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-033 SHALL test 8N1 frame 0xA5 -> out_data=0xA5, out_valid=1, frame_err=0, parity_err=0.
REQ-034 SHALL test rx low for 3 cycles then high -> no out_valid, busy returns 0 within 8 cycles.
REQ-035 SHALL test 0x3C with stop bit 0 -> out_valid=1, out_data=0x3C, frame_err=1.
REQ-036 SHALL test PARITY_MODE=1, 0x07 with parity bit 0 -> parity_err=1; parity bit 1 -> parity_err=0.
REQ-037 SHALL test frames 0x11 then 0x22 with out_ready=0 -> out_data=0x22, overrun=1; out_ready pulse clears out_valid and overrun.
REQ-038 SHALL test rst low mid-DATA -> all outputs 0 immediately; following 0x5A frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // data_xor is the XOR of all data bits; returns 1 when the received parity disagrees.
  function automatic logic parity_bad(int mode, logic data_xor, logic par);
    case (mode)
      PARITY_EVEN: return data_xor ^ par;
      PARITY_ODD:  return ~(data_xor ^ par);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle level (1).
// Latency 2 cycles, no backpressure.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start/data/parity/stop framing into a one-word output register with overrun flag.
// Word valid one cycle after the final stop sample; held until out_ready; UART_RX_SYNC_EN adds a 2-flop input synchronizer.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rx),
    .dout (rx_s)
  );
`else
  assign rx_s = rx;
`endif

  rx_state_t state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 done;
  logic                 tick, mid_tick, load;

  always_comb begin
    state_nxt = state;
    tick      = (cnt == BIT_LAST);
    mid_tick  = (cnt == HALF_LAST);
    load      = 1'b0;
    case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START:  if (mid_tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:   if (tick && idx == IDX_LAST)
                state_nxt = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
      PARITY: if (tick) state_nxt = STOP;
      STOP:   if (done) begin
                load      = 1'b1;
                state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Bit timing and frame assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          idx      <= '0;
          stop_idx <= 1'b0;
          ferr_acc <= 1'b0;
        end
        START: cnt <= mid_tick ? '0 : cnt + CW'(1);
        DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (tick) begin
            cnt     <= '0;
            par_bit <= rx_s;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (done) begin
            cnt <= '0;
          end else if (tick) begin
            cnt      <= '0;
            ferr_acc <= ferr_acc | ~rx_s;
            stop_idx <= stop_idx + 1'b1;
            done     <= (stop_idx == STOP_LAST);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  logic handshake;
  assign handshake = out_valid & out_ready;

  // A word landing while the previous one is still unconsumed overwrites it and sets overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      out_data   <= shreg;
      out_valid  <= 1'b1;
      frame_err  <= ferr_acc;
      parity_err <= parity_bad(PARITY_MODE, ^shreg, par_bit);
      overrun    <= handshake ? 1'b0 : (out_valid | overrun);
    end else if (handshake) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench: an 8N1 instance and an 8E1 instance, directed frames with hand-computed results.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_n = 1'b1, rx_e = 1'b1;
  logic rdy_n = 1'b1, rdy_e = 1'b1;
  logic [7:0] data_n, data_e;
  logic vld_n, vld_e, ferr_n, ferr_e, perr_n, perr_e, ovr_n, ovr_e, busy_n, busy_e;

  int total = 0;
  int bad = 0;

  // Expected words packed as {overrun, parity_err, frame_err, data}.
  logic [10:0] q_n[$];
  logic [10:0] q_e[$];
  logic [10:0] exp_n, exp_e;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst(rst), .rx(rx_n), .out_data(data_n), .out_valid(vld_n), .out_ready(rdy_n),
    .frame_err(ferr_n), .parity_err(perr_n), .overrun(ovr_n), .busy(busy_n)
  );

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .rx(rx_e), .out_data(data_e), .out_valid(vld_e), .out_ready(rdy_e),
    .frame_err(ferr_e), .parity_err(perr_e), .overrun(ovr_e), .busy(busy_e)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_bit(int dut, logic b);
    if (dut == 0) rx_n = b;
    else          rx_e = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(int dut, logic [7:0] d, bit has_par, logic par, logic stop);
    drive_bit(dut, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(dut, d[i]);
    if (has_par) drive_bit(dut, par);
    drive_bit(dut, stop);
    drive_bit(dut, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst && vld_n && rdy_n) begin
      if (q_n.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word_n: got %h expected none", data_n);
      end else begin
        exp_n = q_n.pop_front();
        check("word_n", 32'({ovr_n, perr_n, ferr_n, data_n}), 32'(exp_n));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && vld_e && rdy_e) begin
      if (q_e.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word_e: got %h expected none", data_e);
      end else begin
        exp_e = q_e.pop_front();
        check("word_e", 32'({ovr_e, perr_e, ferr_e, data_e}), 32'(exp_e));
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_n", 32'(data_n), 0);
    check("rst_flags_n", 32'({vld_n, ferr_n, perr_n, ovr_n, busy_n}), 0);
    check("rst_flags_e", 32'({vld_e, ferr_e, perr_e, ovr_e, busy_e}), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Clean 8N1 frame.
    q_n.push_back({1'b0, 1'b0, 1'b0, 8'hA5});
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);

    // Short low pulse must be rejected as a glitch.
    rx_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_n = 1'b1;
    check("glitch_busy_hi", 32'(busy_n), 1);
    n = 0;
    while (busy_n && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("glitch_busy_lo", 32'(busy_n), 0);
    repeat (4) @(posedge clk);
    #1;

    // Stop bit low: frame delivered with frame_err.
    q_n.push_back({1'b0, 1'b0, 1'b1, 8'h3C});
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Even parity: 0x07 has three ones, so parity bit 1 is correct and 0 is wrong.
    q_e.push_back({1'b0, 1'b1, 1'b0, 8'h07});
    send(1, 8'h07, 1'b1, 1'b0, 1'b1);
    q_e.push_back({1'b0, 1'b0, 1'b0, 8'h07});
    send(1, 8'h07, 1'b1, 1'b1, 1'b1);

    // Two frames with the consumer stalled: second overwrites the first.
    rdy_n = 1'b0;
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    q_n.push_back({1'b1, 1'b0, 1'b0, 8'h22});
    send(0, 8'h22, 1'b0, 1'b0, 1'b1);
    check("ovr_vld_held", 32'(vld_n), 1);
    check("ovr_flag_set", 32'(ovr_n), 1);
    rdy_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_n = 1'b0;
    @(negedge clk);
    check("ovr_vld_clr", 32'(vld_n), 0);
    check("ovr_flag_clr", 32'(ovr_n), 0);
    check("ovr_data_kept", 32'(data_n), 32'h22);
    @(posedge clk);
    #1;
    rdy_n = 1'b1;

    // Reset in the middle of the data bits.
    rx_n = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rx_n = 1'b1;
    repeat (CPB + 4) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy_n), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_n), 0);
    check("mid_rst_flags", 32'({vld_n, ferr_n, perr_n, ovr_n, busy_n}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
    q_n.push_back({1'b0, 1'b0, 1'b0, 8'h5A});
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1);

    n = 0;
    while ((q_n.size() != 0 || q_e.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("q_n_empty", 32'(q_n.size()), 0);
    check("q_e_empty", 32'(q_e.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
